// File: rtl/apu_pkg.sv
// Shared APU constants: default frame-sequencer step counts and mode encoding.
// Pure declarations; no logic, latency or flow control.
package apu_pkg;

   localparam int STEP1_DEF = 7457;
   localparam int STEP2_DEF = 14913;
   localparam int STEP3_DEF = 22371;
   localparam int STEP4_DEF = 29829;
   localparam int STEP5_DEF = 37281;
   localparam int CW_DEF    = 16;

   typedef enum logic {
      MODE_4STEP = 1'b0,
      MODE_5STEP = 1'b1
   } apu_mode_e;

endpackage

// File: rtl/apu_tick_detect.sv
// Rising-edge detector for the prescaler's apu_clk; tick is combinational, one clk wide.
// No backpressure: every rising edge produces exactly one tick.
module apu_tick_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic apu_clk,
   output logic tick
);

   logic apu_clk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) apu_clk_q <= 1'b0;
      else        apu_clk_q <= apu_clk;
   end

   assign tick = apu_clk & ~apu_clk_q;

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: counts ticks, issues quarter/half-frame strobes and the frame IRQ.
// Strobes and IRQ are registered one clk after the tick or config write; no backpressure.
module apu_frame_sequencer
   import apu_pkg::*;
#(
   parameter int STEP1 = STEP1_DEF,
   parameter int STEP2 = STEP2_DEF,
   parameter int STEP3 = STEP3_DEF,
   parameter int STEP4 = STEP4_DEF,
   parameter int STEP5 = STEP5_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       apu_clk,
   input  logic       cfg_we,
   input  logic       cfg_mode,
   input  logic       cfg_irq_inhibit,
   input  logic       irq_ack,
   output logic       quarter_frame,
   output logic       half_frame,
   output logic       frame_irq,
   output logic [2:0] step
);

   localparam logic [CW-1:0] S1 = CW'(STEP1);
   localparam logic [CW-1:0] S2 = CW'(STEP2);
   localparam logic [CW-1:0] S3 = CW'(STEP3);
   localparam logic [CW-1:0] S4 = CW'(STEP4);
   localparam logic [CW-1:0] S5 = CW'(STEP5);

   logic            tick;
   apu_mode_e       mode_q;
   logic            inhibit_q;
   logic [CW-1:0]   count_q;
   logic [2:0]      step_q;
   logic            quarter_q;
   logic            half_q;
   logic            irq_q;

   logic hit1, hit2, hit3, hit4, hit5;
   logic mode5, at_last, last_ev, irq_set;

   apu_tick_detect u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .apu_clk (apu_clk),
      .tick    (tick)
   );

   // Comparators look at the pre-increment count.
   assign hit1    = (count_q == S1);
   assign hit2    = (count_q == S2);
   assign hit3    = (count_q == S3);
   assign hit4    = (count_q == S4);
   assign hit5    = (count_q == S5);
   assign mode5   = (mode_q == MODE_5STEP);
   assign at_last = mode5 ? hit5 : hit4;
   assign last_ev = at_last;
   assign irq_set = tick & hit4 & ~mode5 & ~inhibit_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= MODE_4STEP;
         inhibit_q <= 1'b0;
         count_q   <= '0;
         step_q    <= 3'd0;
         quarter_q <= 1'b0;
         half_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         quarter_q <= 1'b0;
         half_q    <= 1'b0;
         if (cfg_we) begin
            // A write restarts the frame and swallows any coincident tick.
            mode_q    <= apu_mode_e'(cfg_mode);
            inhibit_q <= cfg_irq_inhibit;
            count_q   <= '0;
            step_q    <= 3'd0;
            if (cfg_irq_inhibit || irq_ack) irq_q <= 1'b0;
            if (cfg_mode) begin
               quarter_q <= 1'b1;
               half_q    <= 1'b1;
            end
         end else begin
            if (tick) begin
               count_q   <= at_last ? '0 : count_q + 1'b1;
               if (at_last)                          step_q <= 3'd0;
               else if (hit1 | hit2 | hit3 | hit4)   step_q <= step_q + 3'd1;
               quarter_q <= hit1 | hit2 | hit3 | last_ev;
               half_q    <= hit2 | last_ev;
            end
            if (irq_set)      irq_q <= 1'b1;
            else if (irq_ack) irq_q <= 1'b0;
         end
      end
   end

   assign quarter_frame = quarter_q;
   assign half_frame    = half_q;
   assign frame_irq     = irq_q;
   assign step          = step_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer with short steps (4,8,12,16,20) and a 7:3 prescaler;
// a frame-position model predicts every output cycle, literal tick lists pin the model.
module tb_apu_frame_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       apu_clk;
   logic       cfg_we;
   logic       cfg_mode;
   logic       cfg_irq_inhibit;
   logic       irq_ack;
   logic       quarter_frame;
   logic       half_frame;
   logic       frame_irq;
   logic [2:0] step;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apu_frame_sequencer #(
      .STEP1(4), .STEP2(8), .STEP3(12), .STEP4(16), .STEP5(20), .CW(16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .apu_clk         (apu_clk),
      .cfg_we          (cfg_we),
      .cfg_mode        (cfg_mode),
      .cfg_irq_inhibit (cfg_irq_inhibit),
      .irq_ack         (irq_ack),
      .quarter_frame   (quarter_frame),
      .half_frame      (half_frame),
      .frame_irq       (frame_irq),
      .step            (step)
   );

   // Model: position within the frame; a frame is 17 ticks (4-step) or 21 ticks (5-step).
   // Quarters at positions 4,8,12 and the final position; halves at 8 and the final one.
   int ev[4] = '{4, 8, 12, 16};
   int m_cnt, m_step, tick_no, m_p, m_len;
   bit m_mode, m_inh, m_irq, m_q, m_h, m_prev, m_tick, m_last, m_set;
   int q_log[$];
   int h_log[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0; m_step = 0; tick_no = 0;
         m_mode = 0; m_inh = 0; m_irq = 0; m_q = 0; m_h = 0; m_prev = 0;
      end else begin
         m_tick = apu_clk && !m_prev;
         m_prev = apu_clk;
         m_q = 0; m_h = 0; m_set = 0;
         if (cfg_we) begin
            m_mode = cfg_mode; m_inh = cfg_irq_inhibit;
            m_cnt = 0; tick_no = 0;
            if (cfg_irq_inhibit || irq_ack) m_irq = 0;
            if (cfg_mode) begin m_q = 1; m_h = 1; end
         end else begin
            if (m_tick) begin
               m_len  = m_mode ? 21 : 17;
               m_p    = m_cnt;
               m_last = (m_p == m_len - 1);
               m_q    = (m_p == 4 || m_p == 8 || m_p == 12 || m_last);
               m_h    = (m_p == 8 || m_last);
               m_set  = m_last && !m_mode && !m_inh;
               m_cnt  = (m_p + 1) % m_len;
               tick_no++;
            end
            if (m_set) m_irq = 1;
            else if (irq_ack) m_irq = 0;
         end
         m_step = 0;
         foreach (ev[i]) if (ev[i] < m_cnt) m_step++;
      end
   end

   function automatic void chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endfunction

   task automatic chk_log(input string nm, input int got[$], input int n, input int e[5]);
      chk({nm, "_len"}, got.size(), n);
      if (got.size() == n)
         for (int i = 0; i < n; i++) chk(nm, got[i], e[i]);
   endtask

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("quarter", int'(quarter_frame), int'(m_q));
         chk("half",    int'(half_frame),    int'(m_h));
         chk("irq",     int'(frame_irq),     int'(m_irq));
         chk("step",    int'(step),          m_step);
         if (quarter_frame) q_log.push_back(tick_no);
         if (half_frame)    h_log.push_back(tick_no);
      end
   end

   int pcnt = 0;

   task automatic cyc(input bit we = 0, input bit md = 0, input bit inh = 0, input bit ack = 0);
      @(negedge clk);
      apu_clk = (pcnt < 7);
      pcnt    = (pcnt + 1) % 10;
      cfg_we = we; cfg_mode = md; cfg_irq_inhibit = inh; irq_ack = ack;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ticks(input int target);
      int guard = 0;
      while (tick_no < target && guard < 2000) begin
         cyc();
         guard++;
      end
      if (tick_no < target) chk("tick_timeout", tick_no, target);
   endtask

   // Drive one cycle aligned with the next apu_clk rising edge.
   task automatic on_rise(input bit we, input bit md, input bit inh, input bit ack);
      while (pcnt != 0) cyc();
      cyc(we, md, inh, ack);
   endtask

   task automatic clear_logs();
      q_log.delete();
      h_log.delete();
   endtask

   initial begin
      rst_n = 0; apu_clk = 0; cfg_we = 0; cfg_mode = 0; cfg_irq_inhibit = 0; irq_ack = 0;
      repeat (3) cyc();
      chk("rst_quarter", int'(quarter_frame), 0);
      chk("rst_half",    int'(half_frame), 0);
      chk("rst_irq",     int'(frame_irq), 0);
      chk("rst_step",    int'(step), 0);
      rst_n = 1;

      // 4-step frame from reset
      clear_logs();
      wait_ticks(17);
      chk_log("t1_q", q_log, 4, '{5, 9, 13, 17, 0});
      chk_log("t1_h", h_log, 2, '{9, 17, 0, 0, 0});
      chk("t1_irq", int'(frame_irq), 1);
      chk("t1_step", int'(step), 0);
      cyc(0, 0, 0, 1);
      chk("t1_ack", int'(frame_irq), 0);

      // 5-step with immediate clocking
      clear_logs();
      cyc(1, 1, 0, 0);
      wait_ticks(21);
      chk_log("t2_q", q_log, 5, '{0, 5, 9, 13, 21});
      chk_log("t2_h", h_log, 3, '{0, 9, 21, 0, 0});
      chk("t2_irq", int'(frame_irq), 0);

      // inhibit blocks and clears the IRQ
      clear_logs();
      cyc(1, 0, 1, 0);
      wait_ticks(17);
      chk("t3_noirq", int'(frame_irq), 0);
      chk_log("t3_q", q_log, 4, '{5, 9, 13, 17, 0});
      cyc(1, 0, 0, 0);
      wait_ticks(17);
      chk("t3_irq", int'(frame_irq), 1);
      cyc(1, 0, 1, 0);
      chk("t3_clr", int'(frame_irq), 0);

      // ack, and ack coincident with the IRQ-setting tick
      cyc(1, 0, 0, 0);
      wait_ticks(17);
      chk("t4_irq", int'(frame_irq), 1);
      cyc(0, 0, 0, 1);
      chk("t4_ack", int'(frame_irq), 0);
      wait_ticks(33);
      on_rise(0, 0, 0, 1);
      chk("t4_setwins", int'(frame_irq), 1);

      // config write coincident with a tick at count 7
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0);
      wait_ticks(7);
      clear_logs();
      on_rise(1, 0, 0, 0);
      chk("t5_q", int'(quarter_frame), 0);
      chk("t5_step", int'(step), 0);
      wait_ticks(5);
      chk_log("t5_log", q_log, 1, '{5, 0, 0, 0, 0});

      // asynchronous reset mid-frame
      cyc(1, 0, 0, 0);
      wait_ticks(27);
      chk("t6_irq", int'(frame_irq), 1);
      chk("t6_step", int'(step), 2);
      rst_n = 0;
      #1;
      chk("t6_rst_irq",  int'(frame_irq), 0);
      chk("t6_rst_step", int'(step), 0);
      chk("t6_rst_q",    int'(quarter_frame), 0);
      chk("t6_rst_h",    int'(half_frame), 0);
      cyc(); cyc();
      rst_n = 1;
      clear_logs();
      wait_ticks(5);
      chk_log("t6_log", q_log, 1, '{5, 0, 0, 0, 0});
      chk("t6_irq_after", int'(frame_irq), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
